// File: rtl/dma_ctrl_if.sv
// Bundles the CPU register-access bus and the DMA side of the shared system bus.
// slave = the dma_ctrl side, master = the SoC/top-level side.
interface dma_ctrl_if;
  logic        i_we;
  logic [15:0] i_addr;
  logic [15:0] i_wdata;
  logic [15:0] o_rdata;
  logic [15:0] i_rdata;
  logic        o_bus_req;
  logic [15:0] o_addr;
  logic        o_we;
  logic [15:0] o_wdata;
  logic        o_cpu_ce;
  logic        o_int;

  modport slave (
    input  i_we, i_addr, i_wdata, i_rdata,
    output o_rdata, o_bus_req, o_addr, o_we, o_wdata, o_cpu_ce, o_int
  );

  modport master (
    output i_we, i_addr, i_wdata, i_rdata,
    input  o_rdata, o_bus_req, o_addr, o_we, o_wdata, o_cpu_ce, o_int
  );
endinterface

// File: rtl/dma_ctrl.sv
// Memory-mapped word-copy DMA engine and CPU/DMA bus arbiter with periodic CPU yield.
// Optional feature macro: DMA_FILL_EN (pattern fill mode, 1 cycle/word).
module dma_ctrl #(
    parameter logic [15:0] BASE  = 16'h0440,
    parameter int unsigned BURST = 8
) (
    input  logic     i_clk,
    input  logic     i_reset_n,
    dma_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_READ, S_WRITE, S_YIELD, S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [15:0] src, dst, len;
    logic        src_inc, dst_inc, ie, done;
    logic [7:0]  burst_cnt;
    logic        fill;
    logic [15:0] pattern;

    logic [3:0]  off;
    logic        busy, cpu_wr, regs_wr, wr_ctrl;
    logic        start, abort, clr_done, done_set, done_clr;
    logic        last_word, burst_end;

    // Register accesses are honoured only while the CPU is actually clocked.
    assign off       = bus.i_addr[3:0];
    assign busy      = (state != S_IDLE);
    assign cpu_wr    = bus.i_we && (bus.i_addr[15:4] == BASE[15:4]) && bus.o_cpu_ce;
    assign regs_wr   = cpu_wr && !busy;
    assign wr_ctrl   = cpu_wr && (off == 4'd3);
    assign start     = wr_ctrl && !busy && bus.i_wdata[0];
    assign abort     = wr_ctrl && bus.i_wdata[6];
    assign clr_done  = wr_ctrl && bus.i_wdata[7];
    assign last_word = (len == 16'd1);
    assign burst_end = (burst_cnt == 8'(BURST - 1));

    assign done_set = (state == S_WRITE && last_word) || (state == S_YIELD && abort)
                    || (start && len == 16'd0);
    assign done_clr = (start && len != 16'd0) || clr_done;

`ifdef DMA_FILL_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fill    <= 1'b0;
            pattern <= '0;
        end else begin
            if (regs_wr && off == 4'd3) fill    <= bus.i_wdata[4];
            if (regs_wr && off == 4'd4) pattern <= bus.i_wdata;
        end
    end
`else
    assign fill    = 1'b0;
    assign pattern = '0;
`endif

    // NOTE: state is updated with <= so every flop samples pre-edge values, like real hardware.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_nx;
    end

    // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start && len != 16'd0) state_nx = S_GRANT;
            S_GRANT: state_nx = fill ? S_WRITE : S_READ;
            S_READ:  state_nx = S_WRITE;
            S_WRITE: begin
                if (last_word)      state_nx = S_DONE;
                else if (burst_end) state_nx = S_YIELD;
                else                state_nx = fill ? S_WRITE : S_READ;
            end
            S_YIELD: state_nx = abort ? S_IDLE : S_GRANT;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            src       <= '0;
            dst       <= '0;
            len       <= '0;
            src_inc   <= 1'b0;
            dst_inc   <= 1'b0;
            ie        <= 1'b0;
            done      <= 1'b0;
            burst_cnt <= '0;
        end else begin
            if (regs_wr) begin
                unique case (off)
                    4'd0: src <= bus.i_wdata;
                    4'd1: dst <= bus.i_wdata;
                    4'd2: len <= bus.i_wdata;
                    4'd3: begin
                        src_inc <= bus.i_wdata[1];
                        dst_inc <= bus.i_wdata[2];
                        ie      <= bus.i_wdata[3];
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE) begin
                len       <= len - 16'd1;
                burst_cnt <= burst_end ? 8'd0 : burst_cnt + 8'd1;
                if (src_inc && !fill) src <= src + 16'd1;
                if (dst_inc)          dst <= dst + 16'd1;
            end
            if (start) burst_cnt <= '0;
            // A coincident set beats CLR_DONE.
            if (done_set)      done <= 1'b1;
            else if (done_clr) done <= 1'b0;
        end
    end

    always_comb begin
        bus.o_bus_req = (state == S_GRANT) || (state == S_READ) || (state == S_WRITE);
        bus.o_cpu_ce  = (state == S_IDLE) || (state == S_YIELD);
        bus.o_we      = (state == S_WRITE);
        bus.o_addr    = '0;
        bus.o_wdata   = '0;
        if (state == S_READ)  bus.o_addr = src;
        if (state == S_WRITE) begin
            bus.o_addr  = dst;
            bus.o_wdata = fill ? pattern : bus.i_rdata;
        end
    end

    assign bus.o_int = done & ie;

    always_comb begin
        bus.o_rdata = '0;
        if (bus.i_addr[15:4] == BASE[15:4]) begin
            unique case (off)
                4'd0:    bus.o_rdata = src;
                4'd1:    bus.o_rdata = dst;
                4'd2:    bus.o_rdata = len;
                4'd3:    bus.o_rdata = {6'd0, done, busy, 3'd0, fill, ie, dst_inc, src_inc, 1'b0};
                4'd4:    bus.o_rdata = pattern;
                default: bus.o_rdata = '0;
            endcase
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^{bus.i_wdata[15:8], bus.i_wdata[5], bus.i_wdata[4]};

endmodule

// File: tb/tb_dma_ctrl.sv
// Randomized and directed bench for dma_ctrl: a RAM on the system bus plus a
// sequential reference model of the copy (addresses, data, CPU stall timing).
module tb_dma_ctrl;
  localparam logic [15:0] BASE  = 16'h0440;
  localparam int          BURST = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_ctrl_if bus ();
  dma_ctrl #(.BASE(BASE), .BURST(BURST)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];

  // System RAM: read data is registered, writes happen only when the DMA owns the bus.
  always @(posedge clk) begin
    bus.i_rdata <= mem[bus.o_bus_req ? bus.o_addr : bus.i_addr];
    if (bus.o_bus_req && bus.o_we) mem[bus.o_addr] <= bus.o_wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] wr_q[$], rd_q[$], exp_wr_q[$], exp_rd_q[$];
  int low_cyc, yields, n_wr;
  logic int_after_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_word(input logic [15:0] a, input logic [15:0] v);
    mem[a] <= v;
    ref_mem[a] = v;
  endtask

  task automatic reg_wr(input logic [3:0] off, input logic [15:0] d);
    bus.i_addr  = BASE | {12'd0, off};
    bus.i_wdata = d;
    bus.i_we    = 1'b1;
    @(posedge clk); #1;
    bus.i_we    = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] off, output logic [15:0] d);
    bus.i_addr = BASE | {12'd0, off};
    #1;
    d = bus.o_rdata;
  endtask

  // Word-by-word reference of the transfer, in program order.
  task automatic model_xfer(input logic [15:0] s, input logic [15:0] d, input int n,
                            input bit sinc, input bit dinc, input bit fill, input logic [15:0] pat);
    exp_wr_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < n; i++) begin
      if (fill) ref_mem[d] = pat;
      else begin
        exp_rd_q.push_back(s);
        ref_mem[d] = ref_mem[s];
        if (sinc) s = s + 16'd1;
      end
      exp_wr_q.push_back(d);
      if (dinc) d = d + 16'd1;
    end
  endtask

  // Called right after the START edge; watches the bus until two idle cycles in a row.
  task automatic run_xfer(input bit do_abort);
    int ones = 0;
    bit aborted = 0, prev_wr = 0, finished = 0;
    logic [15:0] prev_addr = '0;
    wr_q.delete(); rd_q.delete();
    low_cyc = 0; yields = 0; n_wr = 0; int_after_last = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (prev_wr) int_after_last = bus.o_int;
      prev_wr = bus.o_bus_req && bus.o_we;
      if (prev_wr) begin
        n_wr++;
        wr_q.push_back(bus.o_addr);
        rd_q.push_back(prev_addr);
      end
      prev_addr = bus.o_addr;
      if (!bus.o_cpu_ce) begin
        low_cyc++;
        if (ones == 1) yields++;
        ones = 0;
      end else begin
        ones++;
        if (ones == 1 && do_abort && !aborted) begin
          aborted = 1;
          bus.i_addr = BASE | 16'd3; bus.i_wdata = 16'h0040; bus.i_we = 1'b1;
        end
        if (ones == 2) finished = 1;
      end
      if (!finished) begin
        @(posedge clk); #1;
        bus.i_we = 1'b0;
      end
    end
    if (!finished) check("xfer_timeout", 1, 0);
  endtask

  task automatic cmp_queues(input string tag, input bit rd_too);
    check({tag, "_nwr"}, wr_q.size(), exp_wr_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++)
      if (wr_q[i] !== exp_wr_q[i]) begin check({tag, "_waddr"}, wr_q[i], exp_wr_q[i]); break; end
    if (rd_too)
      for (int i = 0; i < rd_q.size() && i < exp_rd_q.size(); i++)
        if (rd_q[i] !== exp_rd_q[i]) begin check({tag, "_raddr"}, rd_q[i], exp_rd_q[i]); break; end
    begin
      int bad = 0;
      foreach (exp_wr_q[i]) if (mem[exp_wr_q[i]] !== ref_mem[exp_wr_q[i]]) bad++;
      check({tag, "_data"}, bad, 0);
    end
  endtask

  initial begin
    logic [15:0] r, s, d, v;
    int n;
    bit sinc, dinc, ien;
    bus.i_we = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
    end
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_bus_req", bus.o_bus_req, 0);
    check("rst_we", bus.o_we, 0);
    check("rst_addr", bus.o_addr, 0);
    check("rst_wdata", bus.o_wdata, 0);
    check("rst_cpu_ce", bus.o_cpu_ce, 1);
    check("rst_int", bus.o_int, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin reg_rd(4'(k), r); check("rst_reg", r, 0); end

    // Basic copy of four known words
    for (int i = 0; i < 4; i++) set_word(16'h0100 + 16'(i), 16'h00A1 + 16'(i));
    reg_wr(0, 16'h0100); reg_wr(1, 16'h0200); reg_wr(2, 16'd4);
    model_xfer(16'h0100, 16'h0200, 4, 1, 1, 0, '0);
    reg_wr(3, 16'h000F);
    run_xfer(0);
    check("basic_low", low_cyc, 10);
    cmp_queues("basic", 1);
    for (int i = 0; i < 4; i++) check("basic_word", mem[16'h0200 + 16'(i)], 16'h00A1 + 16'(i));
    check("basic_int_timing", int_after_last, 1);
    reg_rd(3, r); check("basic_status", r, 16'h020E);
    check("basic_int", bus.o_int, 1);
    reg_wr(3, 16'h0088);
    check("clr_done_int", bus.o_int, 0);

    // Yield slots after words 8 and 16
    reg_wr(0, 16'h1000); reg_wr(1, 16'h2000); reg_wr(2, 16'd20);
    model_xfer(16'h1000, 16'h2000, 20, 1, 1, 0, '0);
    reg_wr(3, 16'h0007);
    run_xfer(0);
    check("yield_count", yields, 2);
    check("yield_low", low_cyc, 44);
    cmp_queues("yield", 1);

    // Abort in the first yield
    reg_wr(0, 16'h3000); reg_wr(1, 16'h5000); reg_wr(2, 16'd20);
    model_xfer(16'h3000, 16'h5000, 8, 1, 1, 0, '0);
    reg_wr(3, 16'h0007);
    run_xfer(1);
    check("abort_low", low_cyc, 17);
    cmp_queues("abort", 1);
    reg_rd(2, r); check("abort_len", r, 16'd12);
    reg_rd(0, r); check("abort_src", r, 16'h3008);
    reg_rd(1, r); check("abort_dst", r, 16'h5008);
    reg_rd(3, r); check("abort_status", r, 16'h0206);

    // Source address wrap
    reg_wr(0, 16'hFFFE); reg_wr(1, 16'h0700); reg_wr(2, 16'd3);
    model_xfer(16'hFFFE, 16'h0700, 3, 1, 0, 0, '0);
    reg_wr(3, 16'h0003);
    run_xfer(0);
    cmp_queues("wrap", 1);
    check("wrap_rd0", rd_q.size() > 0 ? rd_q[0] : 16'hxxxx, 16'hFFFE);
    check("wrap_rd2", rd_q.size() > 2 ? rd_q[2] : 16'hxxxx, 16'h0000);
    reg_rd(0, r); check("wrap_src_end", r, 16'h0001);

    // Zero-length start
    reg_wr(3, 16'h0080);
    reg_rd(3, r); check("len0_pre_done", r[9], 0);
    reg_wr(2, 16'd0);
    reg_wr(3, 16'h0009);
    reg_rd(3, r); check("len0_status", r, 16'h0208);
    check("len0_int", bus.o_int, 1);
    begin
      int seen = 0;
      repeat (8) begin @(posedge clk); #1; if (bus.o_bus_req || !bus.o_cpu_ce) seen++; end
      check("len0_no_req", seen, 0);
    end

`ifdef DMA_FILL_EN
    reg_wr(4, 16'hBEEF); reg_wr(1, 16'h0300); reg_wr(2, 16'd5);
    model_xfer(16'h0000, 16'h0300, 5, 0, 1, 1, 16'hBEEF);
    reg_wr(3, 16'h0015);
    run_xfer(0);
    check("fill_low", low_cyc, 7);
    cmp_queues("fill", 0);
`else
    reg_wr(3, 16'h0010);
    reg_rd(3, r); check("nofill_bit", r[4], 0);
    reg_rd(4, r); check("nofill_pattern", r, 0);
    reg_wr(0, 16'h0900); reg_wr(1, 16'h0A00); reg_wr(2, 16'd5);
    model_xfer(16'h0900, 16'h0A00, 5, 1, 1, 0, '0);
    reg_wr(3, 16'h0017);
    run_xfer(0);
    check("nofill_low", low_cyc, 12);
    cmp_queues("nofill", 1);
`endif

    // Randomized transfers
    for (int t = 0; t < 8; t++) begin
      n    = $urandom_range(1, 30);
      s    = 16'($urandom);
      d    = s + 16'h4000 + 16'($urandom_range(0, 16'h7000));
      sinc = 1'($urandom); dinc = 1'($urandom); ien = 1'($urandom);
      reg_wr(0, s); reg_wr(1, d); reg_wr(2, 16'(n));
      model_xfer(s, d, n, sinc, dinc, 0, '0);
      reg_wr(3, {8'd0, 4'd0, ien, dinc, sinc, 1'b1});
      run_xfer(0);
      check("rnd_low", low_cyc, 2 * n + 2 + (n - 1) / BURST);
      check("rnd_yields", yields, (n - 1) / BURST);
      cmp_queues("rnd", 1);
      reg_rd(0, r); check("rnd_src_end", r, s + (sinc ? 16'(n) : 16'd0));
      reg_rd(1, r); check("rnd_dst_end", r, d + (dinc ? 16'(n) : 16'd0));
      reg_rd(2, r); check("rnd_len_end", r, 0);
      reg_rd(3, r); check("rnd_status", r, {6'd0, 2'b10, 4'd0, ien, dinc, sinc, 1'b0});
      check("rnd_int", bus.o_int, ien);
    end

    // Asynchronous reset in the middle of a WRITE
    reg_wr(0, 16'h6000); reg_wr(1, 16'h7000); reg_wr(2, 16'd10);
    reg_wr(3, 16'h0007);
    begin
      int w = 0;
      while (!(bus.o_bus_req && bus.o_we) && w < 20) begin @(posedge clk); #1; w++; end
      check("rst_found_write", bus.o_we, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_bus_req", bus.o_bus_req, 0);
    check("arst_we", bus.o_we, 0);
    check("arst_cpu_ce", bus.o_cpu_ce, 1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    begin
      int wrs = 0;
      repeat (30) begin @(posedge clk); #1; if (bus.o_bus_req || bus.o_we) wrs++; end
      check("arst_no_writes", wrs, 0);
    end
    reg_rd(2, r); check("arst_len", r, 0);
    reg_rd(3, r); check("arst_status", r, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_ctrl.md
# dma_ctrl

Memory-mapped DMA controller and bus arbiter for the toy SoC. It shares the single 16-bit system bus between the CPU and a word-copy engine. While a transfer runs, it stalls the CPU through its clock-enable and drives the bus itself. After every BURST words it hands the bus back to the CPU for one cycle, so interrupts and register polling still make progress. Register window: 0x0440–0x044F, muxed into the top-level read-data path like the other peripherals.

## Interface
- BASE, 16'h0440: register window base; decode is i_addr[15:4] == BASE[15:4].
- BURST, 8: words moved per bus tenure before a one-cycle CPU yield; legal range 1–255.
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_we  in  1  CPU bus write strobe.
- i_addr  in  16  CPU bus address.
- i_wdata  in  16  CPU bus write data.
- o_rdata  out  16  register read data; combinational from i_addr[3:0].
- i_rdata  in  16  system bus read data; valid the cycle after the address is presented.
- o_bus_req  out  1  1 = DMA owns the bus; top muxes o_addr/o_we/o_wdata over the CPU's.
- o_addr  out  16  DMA bus address.
- o_we  out  1  DMA bus write strobe.
- o_wdata  out  16  DMA bus write data.
- o_cpu_ce  out  1  CPU clock-enable; 0 while DMA owns the bus.
- o_int  out  1  level interrupt, = DONE & IE.

## Operation
- Registers (word offset in i_addr[3:0]):
  - 0 SRC: source address.
  - 1 DST: destination address.
  - 2 LEN: word count; reads back the remaining count.
  - 3 CTRL/STATUS:
    - Write bits: 0 START, 1 SRC_INC, 2 DST_INC, 3 IE, 4 FILL, 6 ABORT, 7 CLR_DONE. START, ABORT and CLR_DONE are self-clearing strobes.
    - Read: {6'd0, DONE[9], BUSY[8], 3'd0, FILL[4], IE[3], DST_INC[2], SRC_INC[1], 1'b0}.
  - 4 PATTERN: fill value.
  - Offsets 5–15 read 0; writes to them are ignored.
- While BUSY, writes to offsets 0–2 and 4, and a second START, are ignored. CTRL writes still update ABORT and CLR_DONE.
- State machine:
  - IDLE: START with LEN≠0 → GRANT and clears DONE. START with LEN=0 → sets DONE, stays IDLE, no stall.
  - GRANT: o_bus_req=1, o_cpu_ce=0, no access. Lets the CPU's last read data settle. → READ.
  - READ: o_addr=SRC, o_we=0. → WRITE.
  - WRITE: o_addr=DST, o_we=1, o_wdata=i_rdata (combinational). LEN−=1; SRC+=SRC_INC; DST+=DST_INC. Next state:
    - LEN reaches 0 → DONE_ST.
    - Burst count hits BURST → YIELD.
    - Otherwise → READ.
  - YIELD: o_bus_req=0, o_cpu_ce=1 for exactly one cycle. The CPU may access registers during it. → GRANT, or → IDLE with DONE=1 if ABORT was written during YIELD.
  - DONE_ST: releases the bus, sets DONE. → IDLE.
- ABORT is only observable in YIELD, because the CPU is otherwise stalled. Abort leaves SRC/DST/LEN at their values after the last completed word.
- Address arithmetic is 16-bit modulo: 0xFFFF+1 wraps to 0x0000. LEN is 16-bit unsigned, maximum 65535.
- DONE is sticky and cleared only by CLR_DONE or a new START. A simultaneous CLR_DONE and DONE set: set wins.
- Asynchronous reset mid-transfer aborts immediately. All registers go to 0, state IDLE.

## Timing
- Reset values: o_bus_req=0, o_we=0, o_addr=0, o_wdata=0, o_cpu_ce=1, o_int=0, o_rdata reflects zeroed registers.
- START write at edge T → GRANT during cycle T+1 (o_cpu_ce registered, low from T+1).
- Copy throughput: 2 cycles/word. A transfer of N words with N ≤ BURST holds the CPU for 1+2N+1 cycles (GRANT, data, DONE_ST); o_cpu_ce=1 again in IDLE.
- Each YIELD costs 2 cycles of DMA time: YIELD plus GRANT.
- o_int rises the cycle after the final WRITE.

## Configuration
- DMA_FILL_EN defined:
  - FILL bit is implemented.
  - With FILL=1, READ is skipped and WRITE drives o_wdata=PATTERN: 1 cycle/word, SRC unused.
- DMA_FILL_EN undefined:
  - FILL bit reads 0 and is ignored.
  - PATTERN register is absent; it reads 0.

## Test plan
- Basic copy: RAM 0x0100–0x0103 = A1..A4; SRC=0x0100, DST=0x0200, LEN=4, CTRL=0x000F → 0x0200–0x0203 = A1..A4, o_cpu_ce low 10 cycles, DONE=1, o_int=1. CLR_DONE clears o_int.
- Yield: LEN=20, BURST=8 → exactly two one-cycle YIELD slots (after words 8 and 16), o_cpu_ce high in those slots only, 20 words copied.
- Abort: LEN=20; CPU writes CTRL=0x40 during first YIELD → IDLE after 8 words, LEN reads 12, DONE=1, BUSY=0.
- Edge cases: SRC=0xFFFE, LEN=3, SRC_INC → reads 0xFFFE, 0xFFFF, 0x0000. Separately, LEN=0 START → DONE=1 next cycle, o_bus_req never asserted.
- Fill (DMA_FILL_EN): PATTERN=0xBEEF, DST=0x0300, LEN=5, FILL|DST_INC → 0x0300–0x0304 = 0xBEEF, 5 write cycles. Without the macro, CTRL read shows FILL=0 and a copy occurs.
- Reset: assert i_reset_n=0 in the middle of a WRITE → o_bus_req=0, o_we=0, o_cpu_ce=1 immediately, no further writes after release.
